bcd_convert_seq: RTL



---
 rtl/bcd_convert_seq_pkg.sv | 17 +
 rtl/bcd_convert_seq_if.sv | 19 +
 rtl/bcd_convert_seq_add3.sv | 12 +
 rtl/bcd_convert_seq.sv | 89 ++++++++
 4 files changed

// File: rtl/bcd_convert_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
// Any file that needs them pulls them in with import bcd_convert_seq_pkg::*.
package bcd_convert_seq_pkg;

    localparam int NIBBLE    = 4;
    localparam int DIGITS    = 4;
    localparam int BCD_W     = NIBBLE * DIGITS;
    localparam int MAX_WIDTH = 13;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_convert_seq_if.sv
// Start/done bus between a requester and the BCD converter.
// Handshake: a start seen high at a clock edge while busy is low is accepted and data is
// captured at that same edge. The new digits appear together with a one-cycle done pulse.
// The digits then hold until the next done pulse.
interface bcd_convert_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic [3:0]       thous;
    logic [3:0]       huns;
    logic [3:0]       tens;
    logic [3:0]       ones;

    modport master (output start, data, input busy, done, thous, huns, tens, ones);
    modport slave  (input start, data, output busy, done, thous, huns, tens, ones);
endinterface

// File: rtl/bcd_convert_seq_add3.sv
// Double-dabble nibble correction: any digit of 5 or more gets 3 added, so the
// following left shift carries it correctly into the next decimal digit.
module bcd_add3
    import bcd_convert_seq_pkg::*;
(
    input  logic [NIBBLE-1:0] digit,
    output logic [NIBBLE-1:0] fixed
);

    assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_convert_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter. It takes one shift per input bit.
// The result is registered, so the display never sees the digits partway through a conversion.
module bcd_convert_seq
    import bcd_convert_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    bcd_convert_seq_if.slave  bus,
    output state_t            dbg_state
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("bcd_convert_seq: WIDTH must be in 1..%0d", MAX_WIDTH);
    end

    state_t             state;
    state_t             state_next;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   corrected;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   result;
    logic               done_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (scratch[g*NIBBLE +: NIBBLE]),
            .fixed (corrected[g*NIBBLE +: NIBBLE])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The binary MSB is shifted into the bottom of the corrected scratch register.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
            result  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.data;
                        scratch <= '0;
                        cnt     <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    scratch <= {corrected[BCD_W-2:0], shreg[WIDTH-1]};
                    shreg   <= shreg << 1;
                    cnt     <= cnt - 1'b1;
                end
                DONE: begin
                    result <= scratch;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.thous = result[15:12];
    assign bus.huns  = result[11:8];
    assign bus.tens  = result[7:4];
    assign bus.ones  = result[3:0];
    assign dbg_state = state;

endmodule
